// File: rtl/arm_mc_pkg.sv
// Shared types, opcode constants and the condition-code helper for the multicycle ARM core.
package arm_mc_pkg;

  typedef enum logic [3:0] {
    START, FETCH, DECODE, EXECR, EXECI, ALUWB, MEMADR, MEMRD, MEMWB, MEMWR, BRANCH
  } state_t;

  typedef enum logic [2:0] {
    ALU_AND, ALU_EOR, ALU_SUB, ALU_ADD, ALU_ORR
  } alu_op_t;

  typedef enum logic [3:0] {
    COND_EQ = 4'h0, COND_NE = 4'h1, COND_CS = 4'h2, COND_CC = 4'h3,
    COND_MI = 4'h4, COND_PL = 4'h5, COND_VS = 4'h6, COND_VC = 4'h7,
    COND_HI = 4'h8, COND_LS = 4'h9, COND_GE = 4'hA, COND_LT = 4'hB,
    COND_GT = 4'hC, COND_LE = 4'hD, COND_AL = 4'hE
  } cond_t;

  localparam logic [3:0] OP_AND = 4'h0;
  localparam logic [3:0] OP_EOR = 4'h1;
  localparam logic [3:0] OP_SUB = 4'h2;
  localparam logic [3:0] OP_ADD = 4'h4;
  localparam logic [3:0] OP_CMP = 4'hA;
  localparam logic [3:0] OP_ORR = 4'hC;

  localparam int unsigned FLAG_N = 3;
  localparam int unsigned FLAG_Z = 2;
  localparam int unsigned FLAG_C = 1;
  localparam int unsigned FLAG_V = 0;

  // Evaluate an ARM condition field against NZCV; code 4'hF never passes.
  function automatic logic cond_pass(input logic [3:0] cond, input logic [3:0] f);
    logic n, z, c, v;
    n = f[FLAG_N];
    z = f[FLAG_Z];
    c = f[FLAG_C];
    v = f[FLAG_V];
    case (cond)
      COND_EQ: cond_pass = z;
      COND_NE: cond_pass = ~z;
      COND_CS: cond_pass = c;
      COND_CC: cond_pass = ~c;
      COND_MI: cond_pass = n;
      COND_PL: cond_pass = ~n;
      COND_VS: cond_pass = v;
      COND_VC: cond_pass = ~v;
      COND_HI: cond_pass = c & ~z;
      COND_LS: cond_pass = ~c | z;
      COND_GE: cond_pass = (n == v);
      COND_LT: cond_pass = (n != v);
      COND_GT: cond_pass = ~z & (n == v);
      COND_LE: cond_pass = z | (n != v);
      COND_AL: cond_pass = 1'b1;
      default: cond_pass = 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/arm_mc_alu.sv
// Combinational 32-bit ALU with NZCV generation (C on SUB means no borrow).
module arm_mc_alu import arm_mc_pkg::*; (
  input  logic [31:0] a,
  input  logic [31:0] b,
  input  alu_op_t     op,
  output logic [31:0] y,
  output logic [3:0]  nzcv
);

  logic [32:0] sum;

  // Result and flag computation
  always_comb begin
    sum  = '0;
    y    = '0;
    nzcv = '0;
    case (op)
      ALU_AND: y = a & b;
      ALU_EOR: y = a ^ b;
      ALU_ORR: y = a | b;
      ALU_ADD: sum = {1'b0, a} + {1'b0, b};
      ALU_SUB: sum = {1'b0, a} + {1'b0, ~b} + 33'd1;
      default: y = '0;
    endcase
    if (op == ALU_ADD || op == ALU_SUB) y = sum[31:0];
    nzcv[FLAG_N] = y[31];
    nzcv[FLAG_Z] = (y == '0);
    nzcv[FLAG_C] = sum[32];
    if (op == ALU_ADD)      nzcv[FLAG_V] = (a[31] == b[31]) && (y[31] != a[31]);
    else if (op == ALU_SUB) nzcv[FLAG_V] = (a[31] != b[31]) && (y[31] != a[31]);
  end

endmodule

// File: rtl/arm_multicycle.sv
// Multicycle ARM-subset core sharing one valid/ready memory port for fetch and data.
module arm_multicycle import arm_mc_pkg::*; #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter bit          RF_RESET = 1'b1
) (
  input  logic        clk,
  input  logic        rst,
  output logic        mem_req,
  output logic        mem_we,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  input  logic [31:0] mem_rdata,
  input  logic        mem_ready,
  output logic [31:0] pc,
  output logic        retire
);

  state_t      state;
  logic [31:0] instr, pc4, a_q, b_q, res_q;
  logic [3:0]  nzcv, res_flags;
  logic [31:0] rf [0:14];

  logic [3:0]  opcode, rn, rd, rm;
  logic        imm_form, s_bit, ld_bit, up_bit, link_bit;
  logic        is_dp, is_mem, is_br, is_cmp, is_arith, cond_ok;
  logic [31:0] imm8, imm12, br_off, rn_val, rm_val, rd_val;

  alu_op_t     alu_op;
  logic [31:0] alu_b, alu_y;
  logic [3:0]  alu_f;

  logic        rf_we;
  logic [3:0]  rf_waddr;
  logic [31:0] rf_wdata, next_pc;

  assign opcode   = instr[24:21];
  assign rn       = instr[19:16];
  assign rd       = instr[15:12];
  assign rm       = instr[3:0];
  assign imm_form = instr[25];
  assign s_bit    = instr[20];
  assign ld_bit   = instr[20];
  assign up_bit   = instr[23];
  assign link_bit = instr[24];
  assign imm8     = {24'h0, instr[7:0]};
  assign imm12    = {20'h0, instr[11:0]};
  assign br_off   = {{6{instr[23]}}, instr[23:0], 2'b00};
  assign is_cmp   = (opcode == OP_CMP);
  assign is_arith = (opcode == OP_ADD) || (opcode == OP_SUB) || (opcode == OP_CMP);
  assign cond_ok  = cond_pass(instr[31:28], nzcv);

  // Register reads; R15 reads as the current instruction address + 8
  always_comb begin
    rn_val = (rn == 4'hF) ? pc + 32'd8 : rf[rn];
    rm_val = (rm == 4'hF) ? pc + 32'd8 : rf[rm];
    rd_val = (rd == 4'hF) ? pc + 32'd8 : rf[rd];
  end

  // Instruction class decode; anything unmatched falls through as a NOP
  always_comb begin
    is_dp = 1'b0;
    if (instr[27:26] == 2'b00 && (imm_form ? instr[11:8] == 4'h0 : instr[11:4] == 8'h00)) begin
      case (opcode)
        OP_AND, OP_EOR, OP_SUB, OP_ADD, OP_ORR: is_dp = 1'b1;
        OP_CMP:                                 is_dp = s_bit;
        default:                                is_dp = 1'b0;
      endcase
    end
    is_mem = (instr[27:26] == 2'b01) && !instr[25] && instr[24] && !instr[22] && !instr[21];
    is_br  = (instr[27:25] == 3'b101);
  end

  // ALU operand and operation select
  always_comb begin
    alu_b  = b_q;
    alu_op = ALU_ADD;
    case (state)
      EXECI:   alu_b = imm8;
      MEMADR: begin
        alu_b  = imm12;
        alu_op = up_bit ? ALU_ADD : ALU_SUB;
      end
      default: alu_b = b_q;
    endcase
    if (state == EXECR || state == EXECI) begin
      case (opcode)
        OP_AND:         alu_op = ALU_AND;
        OP_EOR:         alu_op = ALU_EOR;
        OP_SUB, OP_CMP: alu_op = ALU_SUB;
        OP_ORR:         alu_op = ALU_ORR;
        default:        alu_op = ALU_ADD;
      endcase
    end
  end

  arm_mc_alu u_alu (
    .a    (a_q),
    .b    (alu_b),
    .op   (alu_op),
    .y    (alu_y),
    .nzcv (alu_f)
  );

  // Write-back port, next pc and retire; retire is decoded from state because a
  // store only completes in the cycle mem_ready arrives
  always_comb begin
    rf_we    = 1'b0;
    rf_waddr = rd;
    rf_wdata = res_q;
    next_pc  = pc4;
    retire   = 1'b0;
    case (state)
      DECODE: retire = !cond_ok || !(is_dp || is_mem || is_br);
      ALUWB: begin
        retire = 1'b1;
        rf_we  = !is_cmp && (rd != 4'hF);
        if (!is_cmp && rd == 4'hF) next_pc = {res_q[31:2], 2'b00};
      end
      MEMWB: begin
        retire = 1'b1;
        rf_we  = (rd != 4'hF);
        if (rd == 4'hF) next_pc = {res_q[31:2], 2'b00};
      end
      BRANCH: begin
        retire   = 1'b1;
        rf_we    = link_bit;
        rf_waddr = 4'hE;
        rf_wdata = pc4;
        next_pc  = pc + 32'd8 + br_off;
      end
      MEMWR:   retire = mem_req && mem_ready;
      default: retire = 1'b0;
    endcase
  end

  if (RF_RESET) begin : g_rf_rst
    // Register file with reset-to-zero
    always_ff @(posedge clk or negedge rst) begin
      if (!rst)       rf <= '{default: '0};
      else if (rf_we) rf[rf_waddr] <= rf_wdata;
    end
  end else begin : g_rf_norst
    // Register file without reset
    always_ff @(posedge clk) begin
      if (rf_we) rf[rf_waddr] <= rf_wdata;
    end
  end

  // Instruction sequencer with registered memory-port outputs
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state     <= START;
      mem_req   <= 1'b0;
      mem_we    <= 1'b0;
      mem_addr  <= '0;
      mem_wdata <= '0;
      pc        <= RESET_PC;
      nzcv      <= '0;
      instr     <= '0;
      pc4       <= '0;
      a_q       <= '0;
      b_q       <= '0;
      res_q     <= '0;
      res_flags <= '0;
    end else begin
      case (state)
        START: begin
          mem_req  <= 1'b1;
          mem_addr <= pc;
          state    <= FETCH;
        end
        FETCH: begin
          // Entered with mem_req low only after a store, giving the bus its idle cycle
          if (!mem_req) begin
            mem_req  <= 1'b1;
            mem_addr <= pc;
          end else if (mem_ready) begin
            instr   <= mem_rdata;
            pc4     <= pc + 32'd4;
            mem_req <= 1'b0;
            state   <= DECODE;
          end
        end
        DECODE: begin
          a_q <= rn_val;
          b_q <= is_mem ? rd_val : rm_val;
          if (retire) begin
            pc       <= pc4;
            mem_req  <= 1'b1;
            mem_addr <= pc4;
            state    <= FETCH;
          end else if (is_br)    state <= BRANCH;
          else if (is_mem)       state <= MEMADR;
          else if (imm_form)     state <= EXECI;
          else                   state <= EXECR;
        end
        EXECR, EXECI: begin
          res_q     <= alu_y;
          res_flags <= alu_f;
          state     <= ALUWB;
        end
        ALUWB: begin
          if (s_bit) begin
            nzcv[FLAG_N] <= res_flags[FLAG_N];
            nzcv[FLAG_Z] <= res_flags[FLAG_Z];
            if (is_arith) begin
              nzcv[FLAG_C] <= res_flags[FLAG_C];
              nzcv[FLAG_V] <= res_flags[FLAG_V];
            end
          end
          pc       <= next_pc;
          mem_req  <= 1'b1;
          mem_addr <= next_pc;
          state    <= FETCH;
        end
        MEMADR: begin
          mem_req   <= 1'b1;
          mem_we    <= !ld_bit;
          mem_addr  <= {alu_y[31:2], 2'b00};
          mem_wdata <= b_q;
          state     <= ld_bit ? MEMRD : MEMWR;
        end
        MEMRD: begin
          if (mem_req && mem_ready) begin
            res_q   <= mem_rdata;
            mem_req <= 1'b0;
            state   <= MEMWB;
          end
        end
        MEMWB, BRANCH: begin
          pc       <= next_pc;
          mem_req  <= 1'b1;
          mem_addr <= next_pc;
          state    <= FETCH;
        end
        MEMWR: begin
          if (mem_req && mem_ready) begin
            mem_req <= 1'b0;
            mem_we  <= 1'b0;
            pc      <= pc4;
            state   <= FETCH;
          end
        end
        default: state <= START;
      endcase
    end
  end

endmodule
